keccak_squeezer: RTL and testbench

- Output-side counterpart of the absorb padder. It takes the post-permutation Keccak state and serializes the digest or XOF output as 64-bit lanes over a valid/ready stream.
- When a SHAKE request needs more words than one rate block holds, it asks the permutation core for another round of f_permutation.
- It sits between the f_permutation state output and the hash result consumer.
- Its mode encoding matches the absorb side: 0 SHA3-256, 1 SHA3-512, 2 SHAKE128, 3 SHAKE256.

---
 rtl/keccak_squeezer_if.sv | 31 +++
 rtl/keccak_squeezer.sv | 144 ++++++++++++++
 tb/tb_keccak_squeezer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_squeezer_if.sv
// Stream and control bundle between the permutation core, the squeezer and
// the digest consumer. The master side issues requests, supplies permutation
// results and accepts output words. The slave side is the squeezer.
interface keccak_squeezer_if #(
    parameter int W     = 64,
    parameter int LANES = 25,
    parameter int LEN_W = 16
);
    logic                 start;
    logic [1:0]           mode;
    logic [LEN_W-1:0]     out_len;
    logic [W*LANES-1:0]   state_in;
    logic                 state_valid;
    logic [W-1:0]         out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 perm_req;
    logic                 busy;
    logic                 done;

    modport master (
        output start, mode, out_len, state_in, state_valid, out_ready,
        input  out, out_valid, out_last, perm_req, busy, done
    );

    modport slave (
        input  start, mode, out_len, state_in, state_valid, out_ready,
        output out, out_valid, out_last, perm_req, busy, done
    );
endinterface

// File: rtl/keccak_squeezer.sv
// Keccak squeeze stage: copies the rate portion of a permutation result into
// a lane buffer and streams it out one 64-bit lane per handshake. Requests
// longer than one rate block ask the core for another permutation.
module keccak_squeezer #(
    parameter int W     = 64,
    parameter int LANES = 25,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    keccak_squeezer_if.slave  bus
);
    // Largest rate of the supported modes (SHAKE128), in lanes.
    localparam int MAX_RATE = 21;

    typedef enum logic [2:0] {IDLE, WAIT_ST, EMIT, REQ, FIN} state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [4:0]         rate_last_reg;
    logic [4:0]         lane_idx_reg;
    logic [LEN_W-1:0]   remaining_reg;
    logic [W-1:0]       out_reg;
    logic [W-1:0]       lane_buf_reg [MAX_RATE];

    logic [W-1:0]       state_lane [MAX_RATE];
    logic [4:0]         start_rate_last;
    logic [LEN_W-1:0]   start_len;
    logic               handshake;
    logic               capture;
    logic               is_final;
    logic               at_boundary;
    logic [4:0]         lane_next;
    logic               unused_tail;

    // Split the rate portion of the incoming state into lanes.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_RATE; gi++) begin : g_lane
            assign state_lane[gi] = bus.state_in[W*gi +: W];
        end
    endgenerate

    // Capacity lanes never leave the sponge.
    assign unused_tail = ^bus.state_in[W*LANES-1:W*MAX_RATE];

    // Mode decode: last lane index of the rate block and word count to emit.
    always_comb begin
        start_rate_last = 5'd16;
        start_len       = bus.out_len;
        case (bus.mode)
            2'd0: begin start_rate_last = 5'd16; start_len = LEN_W'(4); end
            2'd1: begin start_rate_last = 5'd8;  start_len = LEN_W'(8); end
            2'd2: begin start_rate_last = 5'd20; start_len = bus.out_len; end
            default: begin start_rate_last = 5'd16; start_len = bus.out_len; end
        endcase
    end

    // Handshake and lane-walk helpers; lane_next wraps at the rate boundary
    // so the buffer index never leaves the rate.
    always_comb begin
        handshake   = (state_reg == EMIT) && bus.out_ready;
        capture     = (state_reg == WAIT_ST) && bus.state_valid;
        is_final    = (remaining_reg == LEN_W'(1));
        at_boundary = (lane_idx_reg == rate_last_reg);
        lane_next   = at_boundary ? 5'd0 : lane_idx_reg + 5'd1;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = (start_len == '0) ? FIN : WAIT_ST;
                end
            end
            WAIT_ST: begin
                if (bus.state_valid) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (is_final) begin
                        state_next = FIN;
                    end else if (at_boundary) begin
                        state_next = REQ;
                    end
                end
            end
            REQ:     state_next = WAIT_ST;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latching, lane capture and the registered output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_last_reg <= '0;
            lane_idx_reg  <= '0;
            remaining_reg <= '0;
            out_reg       <= '0;
            for (int i = 0; i < MAX_RATE; i++) begin
                lane_buf_reg[i] <= '0;
            end
        end else begin
            if ((state_reg == IDLE) && bus.start) begin
                rate_last_reg <= start_rate_last;
                remaining_reg <= start_len;
            end
            if (capture) begin
                for (int i = 0; i < MAX_RATE; i++) begin
                    lane_buf_reg[i] <= state_lane[i];
                end
                lane_idx_reg <= '0;
                out_reg      <= state_lane[0];
            end
            if (handshake) begin
                remaining_reg <= remaining_reg - LEN_W'(1);
                lane_idx_reg  <= lane_next;
                out_reg       <= lane_buf_reg[lane_next];
            end
        end
    end

    // Outputs decoded from registered state only.
    assign bus.out       = out_reg;
    assign bus.out_valid = (state_reg == EMIT);
    assign bus.out_last  = (state_reg == EMIT) && is_final;
    assign bus.perm_req  = (state_reg == REQ);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == FIN);
endmodule

// File: tb/tb_keccak_squeezer.sv
// Directed bench for keccak_squeezer: a table of requests run through a
// generic driver/checker, plus hand-written sequences for ignored events,
// maximum length and reset in the middle of a request.
module tb_keccak_squeezer;
    localparam int W     = 64;
    localparam int LANES = 25;
    localparam int LEN_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    keccak_squeezer_if #(.W(W), .LANES(LANES), .LEN_W(LEN_W)) bus();

    keccak_squeezer #(.W(W), .LANES(LANES), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] out_len;
        logic [7:0]  ready_pat;
        int          exp_words;
        int          exp_perms;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Block b, lane i carries 0x1000*(b+1)+i; capacity lanes carry a marker.
    function automatic logic [W*LANES-1:0] mk_state(input int blk);
        logic [W*LANES-1:0] s;
        for (int i = 0; i < LANES; i++) begin
            if (i < 21) s[W*i +: W] = 64'(blk + 1) * 64'h1000 + 64'(i);
            else        s[W*i +: W] = 64'hDEAD_0000_0000_0000 + 64'(i);
        end
        return s;
    endfunction

    function automatic int rate_of(input logic [1:0] m);
        case (m)
            2'd0:    return 17;
            2'd1:    return 9;
            2'd2:    return 21;
            default: return 17;
        endcase
    endfunction

    function automatic logic [63:0] exp_word(input int k, input int rate);
        return 64'(k / rate + 1) * 64'h1000 + 64'(k % rate);
    endfunction

    task automatic run_vec(input vec_t v);
        logic [63:0] words[$];
        logic        lasts[$];
        int          rate;
        int          hs, perms, blk, bubbles, idle_busy, valid_cycles;
        bit          pending_sv, sv_now, rdy, prev_sv, prev_stall, prev_hs, got_done, ok_done;
        logic [63:0] prev_out;
        logic        prev_last;
        rate = rate_of(v.mode);
        hs = 0; perms = 0; blk = 0; bubbles = 0; idle_busy = 0; valid_cycles = 0;
        prev_sv = 0; prev_stall = 0; prev_hs = 0; got_done = 0;
        prev_out = '0; prev_last = 1'b0;

        bus.mode = v.mode; bus.out_len = v.out_len; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        pending_sv = (v.exp_words != 0);

        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            sv_now = pending_sv;
            pending_sv = 0;
            bus.state_valid = sv_now;
            if (sv_now) bus.state_in = mk_state(blk);
            rdy = v.ready_pat[cyc % 8];
            bus.out_ready = rdy;

            if (prev_sv) chk({v.name, "_latency"}, 64'(bus.out_valid), 64'd1);
            if (prev_stall) begin
                chk({v.name, "_stall_valid"}, 64'(bus.out_valid), 64'd1);
                chk({v.name, "_stall_out"}, bus.out, prev_out);
                chk({v.name, "_stall_last"}, 64'(bus.out_last), 64'(prev_last));
            end
            if (!bus.busy) idle_busy++;
            if (bus.out_valid) valid_cycles++;
            else if (!bus.perm_req && !bus.done && !sv_now) bubbles++;
            if (bus.perm_req) begin
                perms++;
                chk({v.name, "_perm_pos"}, 64'(hs), 64'(rate * perms));
                pending_sv = 1;
                blk++;
            end
            if (bus.done) begin
                got_done = 1;
                chk({v.name, "_done_valid"}, 64'(bus.out_valid), 64'd0);
                ok_done = (hs == v.exp_words) && (v.exp_words == 0 || prev_hs);
                chk({v.name, "_done_timing"}, 64'(ok_done), 64'd1);
            end
            prev_hs = bus.out_valid && rdy;
            if (prev_hs) begin
                words.push_back(bus.out);
                lasts.push_back(bus.out_last);
                hs++;
            end
            prev_stall = bus.out_valid && !rdy;
            prev_out   = bus.out;
            prev_last  = bus.out_last;
            prev_sv    = sv_now;
            if (!got_done) tick();
        end

        bus.state_valid = 1'b0;
        bus.out_ready   = 1'b0;
        if (!got_done) chk({v.name, "_timeout"}, 64'd0, 64'd1);
        tick();
        chk({v.name, "_busy_after"}, 64'(bus.busy), 64'd0);
        chk({v.name, "_done_after"}, 64'(bus.done), 64'd0);

        chk({v.name, "_count"}, 64'(hs), 64'(v.exp_words));
        for (int k = 0; k < v.exp_words && k < words.size(); k++) begin
            chk($sformatf("%s_word%0d", v.name, k), words[k], exp_word(k, rate));
            chk($sformatf("%s_last%0d", v.name, k), 64'(lasts[k]), 64'(k == v.exp_words - 1));
        end
        chk({v.name, "_perms"}, 64'(perms), 64'(v.exp_perms));
        chk({v.name, "_bubbles"}, 64'(bubbles), 64'd0);
        chk({v.name, "_busy_during"}, 64'(idle_busy), 64'd0);
        if (v.exp_words == 0) chk({v.name, "_no_valid"}, 64'(valid_cycles), 64'd0);
        $display("request %s: mode=%0d len=%0d words=%0d perm_reqs=%0d", v.name, v.mode, v.out_len, hs, perms);
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 2'd0; bus.out_len = '0;
        bus.state_in = '0; bus.state_valid = 1'b0; bus.out_ready = 1'b0;

        vecs[0] = '{mode: 2'd0, out_len: 16'd0,  ready_pat: 8'hFF, exp_words: 4,  exp_perms: 0, name: "sha3_256"};
        vecs[1] = '{mode: 2'd1, out_len: 16'd3,  ready_pat: 8'h99, exp_words: 8,  exp_perms: 0, name: "sha3_512_bp"};
        vecs[2] = '{mode: 2'd2, out_len: 16'd25, ready_pat: 8'hFF, exp_words: 25, exp_perms: 1, name: "shake128_25"};
        vecs[3] = '{mode: 2'd3, out_len: 16'd0,  ready_pat: 8'hFF, exp_words: 0,  exp_perms: 0, name: "shake256_zero"};
        vecs[4] = '{mode: 2'd3, out_len: 16'd40, ready_pat: 8'hB5, exp_words: 40, exp_perms: 2, name: "shake256_40"};
        vecs[5] = '{mode: 2'd2, out_len: 16'd21, ready_pat: 8'hFF, exp_words: 21, exp_perms: 0, name: "shake128_21"};
        vecs[6] = '{mode: 2'd2, out_len: 16'd42, ready_pat: 8'h6D, exp_words: 42, exp_perms: 1, name: "shake128_42"};
        vecs[7] = '{mode: 2'd3, out_len: 16'd1,  ready_pat: 8'hFE, exp_words: 1,  exp_perms: 0, name: "shake256_1"};

        // Reset state.
        tick(); tick();
        chk("rst_out",      bus.out, 64'd0);
        chk("rst_valid",    64'(bus.out_valid), 64'd0);
        chk("rst_last",     64'(bus.out_last), 64'd0);
        chk("rst_perm_req", 64'(bus.perm_req), 64'd0);
        chk("rst_busy",     64'(bus.busy), 64'd0);
        chk("rst_done",     64'(bus.done), 64'd0);
        #2 rst = 1'b0;
        tick();

        for (int t = 0; t < 8; t++) run_vec(vecs[t]);

        // start and state_valid during EMIT must be ignored.
        bus.mode = 2'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.state_valid = 1'b1; bus.state_in = mk_state(0);
        tick();
        bus.state_valid = 1'b0; bus.out_ready = 1'b1;
        chk("ign_w0", bus.out, 64'h1000);
        bus.start = 1'b1; bus.mode = 2'd2; bus.out_len = 16'd100;
        bus.state_valid = 1'b1; bus.state_in = mk_state(8);
        tick();
        bus.start = 1'b0; bus.state_valid = 1'b0; bus.mode = 2'd0;
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("ign_valid%0d", k), 64'(bus.out_valid), 64'd1);
            chk($sformatf("ign_w%0d", k), bus.out, 64'h1000 + 64'(k));
            chk($sformatf("ign_last%0d", k), 64'(bus.out_last), 64'(k == 3));
            tick();
        end
        chk("ign_done", 64'(bus.done), 64'd1);
        chk("ign_valid_end", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;
        tick();
        chk("ign_idle", 64'(bus.busy), 64'd0);
        $display("request ignored_events: mode=0 words=4");

        // Maximum length: latched without wrap, first words are not last.
        bus.mode = 2'd3; bus.out_len = 16'hFFFF; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.state_valid = 1'b1; bus.state_in = mk_state(0);
        tick();
        bus.state_valid = 1'b0; bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("max_w%0d", k), bus.out, 64'h1000 + 64'(k));
            chk($sformatf("max_last%0d", k), 64'(bus.out_last), 64'd0);
            tick();
        end
        chk("max_busy", 64'(bus.busy), 64'd1);
        chk("max_done", 64'(bus.done), 64'd0);
        #2 rst = 1'b1;
        tick();
        #2 rst = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        $display("request max_len: mode=3 len=65535 aborted by reset after 3 words");

        // Reset in the middle of a mode-0 request.
        bus.mode = 2'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.state_valid = 1'b1; bus.state_in = mk_state(0);
        tick();
        bus.state_valid = 1'b0; bus.out_ready = 1'b1;
        tick(); tick();
        chk("mid_pre_word", bus.out, 64'h1002);
        #2 rst = 1'b1;
        #1;
        chk("mid_out",      bus.out, 64'd0);
        chk("mid_valid",    64'(bus.out_valid), 64'd0);
        chk("mid_last",     64'(bus.out_last), 64'd0);
        chk("mid_perm_req", 64'(bus.perm_req), 64'd0);
        chk("mid_busy",     64'(bus.busy), 64'd0);
        chk("mid_done",     64'(bus.done), 64'd0);
        bus.out_ready = 1'b0;
        tick();
        #2 rst = 1'b0;
        tick();
        $display("request reset_mid: mode=0 aborted after 2 words");
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
